// File: rtl/handwrite_canvas.sv
// Mouse-driven 30x30 handwriting canvas: cursor tracking, ink painting, clear and stroke-completion timer.
// Optional feature: define HANDWRITE_THICK_EN for a 2x2 brush (default build paints single cells).
module handwrite_canvas #(
  parameter int TIMEOUT = 12_500_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [8:0]   i_movement_x,
  input  logic [8:0]   i_movement_y,
  input  logic         i_button_left,
  input  logic         i_button_right,
  input  logic         i_clear,
  output logic [899:0] o_handwrite,
  output logic [4:0]   o_cursor_x,
  output logic [4:0]   o_cursor_y,
  output logic         o_stroke_done,
  output logic         o_busy
);

  localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [9:0]      POS_RESET = 10'd480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Clamp a signed candidate position into the 0..959 canvas range.
  function automatic logic [9:0] sat_pos(input logic signed [11:0] v);
    logic [9:0] r;
    if (v < 12'sd0) begin
      r = 10'd0;
    end else if (v > 12'sd959) begin
      r = 10'd959;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

  logic [9:0]          px_r, py_r;
  logic [9:0]          px_next_s, py_next_s;
  logic signed [11:0]  dx_ext_s, dy_ext_s, px_sum_s, py_sum_s;
  logic [4:0]          col_s, row_s;
  logic [9:0]          paint_idx_s;
  logic [899:0]        mask_s, canvas_r, canvas_next_s;
  logic                clear_s, paint_s;
  state_t              state_r, state_next_s;
  logic [CW-1:0]       cnt_r, cnt_next_s;
  logic                done_next_s, stroke_done_r, busy_r;

  assign clear_s = i_clear | (i_valid & i_button_right);
  assign paint_s = i_valid & i_button_left;

  // Next cursor position; Y is inverted because PS/2 reports positive = up.
  always_comb begin
    dx_ext_s = {{3{i_movement_x[8]}}, i_movement_x};
    dy_ext_s = {{3{i_movement_y[8]}}, i_movement_y};
    px_sum_s = $signed({2'b00, px_r}) + dx_ext_s;
    py_sum_s = $signed({2'b00, py_r}) - dy_ext_s;
    if (i_valid) begin
      px_next_s = sat_pos(px_sum_s);
      py_next_s = sat_pos(py_sum_s);
    end else begin
      px_next_s = px_r;
      py_next_s = py_r;
    end
  end

  // Brush mask at the cell of the updated cursor position.
  always_comb begin
    col_s       = px_next_s[9:5];
    row_s       = py_next_s[9:5];
    paint_idx_s = {5'd0, row_s} * 10'd30 + {5'd0, col_s};
    mask_s      = '0;
    mask_s[paint_idx_s] = 1'b1;
`ifdef HANDWRITE_THICK_EN
    if (col_s < 5'd29) begin
      mask_s[paint_idx_s + 10'd1] = 1'b1;
    end else begin
      mask_s[paint_idx_s] = 1'b1;
    end
    if (row_s < 5'd29) begin
      mask_s[paint_idx_s + 10'd30] = 1'b1;
    end else begin
      mask_s[paint_idx_s] = 1'b1;
    end
    if ((col_s < 5'd29) && (row_s < 5'd29)) begin
      mask_s[paint_idx_s + 10'd31] = 1'b1;
    end else begin
      mask_s[paint_idx_s] = 1'b1;
    end
`endif
  end

  // Canvas update: clear wins over paint; painting only ever sets bits.
  always_comb begin
    if (clear_s) begin
      canvas_next_s = '0;
    end else if (paint_s) begin
      canvas_next_s = canvas_r | mask_s;
    end else begin
      canvas_next_s = canvas_r;
    end
  end

  // Stroke FSM next-state; the holdoff counter stays at zero outside HOLDOFF.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = '0;
    done_next_s  = 1'b0;
    if (clear_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (paint_s) begin
            state_next_s = ST_DRAW;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DRAW: begin
          if (i_valid && !i_button_left) begin
            state_next_s = ST_HOLDOFF;
          end else begin
            state_next_s = ST_DRAW;
          end
        end
        ST_HOLDOFF: begin
          if (paint_s) begin
            state_next_s = ST_DRAW;
          end else if (cnt_r == CNT_LAST) begin
            state_next_s = ST_IDLE;
            done_next_s  = 1'b1;
          end else begin
            cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Cursor position registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      px_r <= POS_RESET;
      py_r <= POS_RESET;
    end else begin
      px_r <= px_next_s;
      py_r <= py_next_s;
    end
  end

  // Ink bitmap register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      canvas_r <= '0;
    end else begin
      canvas_r <= canvas_next_s;
    end
  end

  // FSM state, holdoff counter and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      stroke_done_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      stroke_done_r <= done_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
    end
  end

  assign o_handwrite   = canvas_r;
  assign o_cursor_x    = px_r[9:5];
  assign o_cursor_y    = py_r[9:5];
  assign o_stroke_done = stroke_done_r;
  assign o_busy        = busy_r;

  handwrite_canvas_chk u_chk (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .px         (px_r),
    .py         (py_r),
    .in_holdoff (state_r == ST_HOLDOFF),
    .cnt_zero   (cnt_r == '0),
    .stroke_done(stroke_done_r),
    .busy       (busy_r)
  );

endmodule

// Invariant checker for the canvas: positions in range, counter idle outside HOLDOFF.
module handwrite_canvas_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [9:0] px,
  input logic [9:0] py,
  input logic       in_holdoff,
  input logic       cnt_zero,
  input logic       stroke_done,
  input logic       busy
);

  a_pos_range: assert property (@(posedge clk) disable iff (!rst_n)
    (px <= 10'd959) && (py <= 10'd959));

  a_cnt_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !in_holdoff |-> cnt_zero);

  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    stroke_done |-> !busy);

endmodule

// File: tb/tb_handwrite_canvas.sv
// Directed self-checking bench for handwrite_canvas (TIMEOUT shortened to 100 cycles).
module tb_handwrite_canvas;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [8:0]   i_movement_x = 9'd0;
  logic [8:0]   i_movement_y = 9'd0;
  logic         i_button_left = 1'b0;
  logic         i_button_right = 1'b0;
  logic         i_clear = 1'b0;
  logic [899:0] o_handwrite;
  logic [4:0]   o_cursor_x, o_cursor_y;
  logic         o_stroke_done, o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  int first_k;

`ifdef HANDWRITE_THICK_EN
  localparam int THICK = 1;
`else
  localparam int THICK = 0;
`endif

  handwrite_canvas #(.TIMEOUT(100)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_movement_x  (i_movement_x),
    .i_movement_y  (i_movement_y),
    .i_button_left (i_button_left),
    .i_button_right(i_button_right),
    .i_clear       (i_clear),
    .o_handwrite   (o_handwrite),
    .o_cursor_x    (o_cursor_x),
    .o_cursor_y    (o_cursor_y),
    .o_stroke_done (o_stroke_done),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #2;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // One-cycle packet; returns on the falling edge after the sampling edge.
  task automatic send(input logic [8:0] dx, input logic [8:0] dy,
                      input logic l, input logic r, input logic c);
    @(negedge i_clk);
    i_valid = 1'b1; i_movement_x = dx; i_movement_y = dy;
    i_button_left = l; i_button_right = r; i_clear = c;
    @(negedge i_clk);
    i_valid = 1'b0; i_movement_x = 9'd0; i_movement_y = 9'd0;
    i_button_left = 1'b0; i_button_right = 1'b0; i_clear = 1'b0;
  endtask

  // Watch o_stroke_done for n falling edges, recording pulse count and first index.
  task automatic watch_done(input int n);
    pulses  = 0;
    first_k = -1;
    for (int k = 0; k < n; k++) begin
      if (o_stroke_done) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      @(negedge i_clk);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_ink", $countones(o_handwrite), 0);
    check_eq("rst_cx", {27'd0, o_cursor_x}, 15);
    check_eq("rst_cy", {27'd0, o_cursor_y}, 15);
    check_eq("rst_busy", {31'd0, o_busy}, 0);
    check_eq("rst_done", {31'd0, o_stroke_done}, 0);

    // Paint after moving right one cell
    send(9'd32, 9'd0, 1'b1, 1'b0, 1'b0);
    check_eq("paint_cx", {27'd0, o_cursor_x}, 16);
    check_eq("paint_cy", {27'd0, o_cursor_y}, 15);
    check_eq("paint_b466", {31'd0, o_handwrite[466]}, 1);
    check_eq("paint_b497", {31'd0, o_handwrite[497]}, THICK);
    check_eq("paint_ink", $countones(o_handwrite), (THICK != 0) ? 4 : 1);
    check_eq("paint_busy", {31'd0, o_busy}, 1);

    // Repaint the same cell is a no-op
    send(9'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    check_eq("repaint_ink", $countones(o_handwrite), (THICK != 0) ? 4 : 1);

    // Release, then silence: stroke completes 100 cycles later
    send(9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_busy", {31'd0, o_busy}, 1);
    watch_done(200);
    check_eq("done_pulses", pulses, 1);
    check_eq("done_at", first_k, 100);
    check_eq("done_busy", {31'd0, o_busy}, 0);
    check_eq("done_ink_kept", {31'd0, o_handwrite[466]}, 1);

    // Saturation at both ends
    do_reset();
    repeat (4) send(9'd255, 9'd0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_cx_hi", {27'd0, o_cursor_x}, 29);
    check_eq("sat_busy", {31'd0, o_busy}, 0);
    send(9'd0, 9'd255, 1'b0, 1'b0, 1'b0);
    check_eq("sat_cy_up", {27'd0, o_cursor_y}, 7);
    repeat (4) send(9'h100, 9'd0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_cx_lo", {27'd0, o_cursor_x}, 0);
    repeat (4) send(9'd0, 9'h100, 1'b0, 1'b0, 1'b0);
    check_eq("sat_cy_hi", {27'd0, o_cursor_y}, 29);

    // Clear plus paint during HOLDOFF: blank canvas, IDLE, no pulse, cursor moves
    do_reset();
    send(9'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    check_eq("clr_pre_b465", {31'd0, o_handwrite[465]}, 1);
    send(9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge i_clk);
    check_eq("clr_pre_busy", {31'd0, o_busy}, 1);
    send(9'd32, 9'd0, 1'b1, 1'b0, 1'b1);
    check_eq("clr_ink", $countones(o_handwrite), 0);
    check_eq("clr_busy", {31'd0, o_busy}, 0);
    check_eq("clr_cx", {27'd0, o_cursor_x}, 16);
    watch_done(150);
    check_eq("clr_no_done", pulses, 0);

    // Right button clears, cursor unchanged
    send(9'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    check_eq("rb_pre_ink", {31'd0, o_handwrite[466]}, 1);
    send(9'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    check_eq("rb_ink", $countones(o_handwrite), 0);
    check_eq("rb_busy", {31'd0, o_busy}, 0);
    check_eq("rb_cx", {27'd0, o_cursor_x}, 16);

    // Level-sampled i_clear alone
    send(9'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    check_eq("iclr_ink", $countones(o_handwrite), 0);
    check_eq("iclr_busy", {31'd0, o_busy}, 0);

    // Bottom-right corner paint: only bit 899 in either build
    do_reset();
    repeat (2) send(9'd255, 9'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) send(9'd0, 9'h100, 1'b0, 1'b0, 1'b0);
    send(9'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    check_eq("corner_b899", {31'd0, o_handwrite[899]}, 1);
    check_eq("corner_ink", $countones(o_handwrite), 1);

    // Asynchronous reset mid-stroke
    send(9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("arst_ink", $countones(o_handwrite), 0);
    check_eq("arst_busy", {31'd0, o_busy}, 0);
    check_eq("arst_cx", {27'd0, o_cursor_x}, 15);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    watch_done(150);
    check_eq("arst_no_done", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handwrite_canvas.md
HANDWRITE_CANVAS -- requirements
Module: handwrite_canvas

Interface
REQ-001 Parameter: TIMEOUT, default 12_500_000, cycles after left-button release before a stroke is declared complete (0.5 s at 25 MHz).
REQ-002 i_clk  input  1  system clock; single clock domain.
REQ-003 i_rst_n  input  1  asynchronous reset, active low.
REQ-004 i_valid  input  1  one-cycle strobe; mouse packet fields valid this cycle.
REQ-005 i_movement_x  input  9  signed two's-complement X delta, range -256..255, positive = right.
REQ-006 i_movement_y  input  9  signed two's-complement Y delta, positive = up (PS/2 convention).
REQ-007 i_button_left  input  1  left button level; sampled only when i_valid=1.
REQ-008 i_button_right  input  1  right button level; sampled only when i_valid=1.
REQ-009 i_clear  input  1  synchronous canvas clear request, level-sampled each cycle.
REQ-010 o_handwrite  output  900  30x30 bitmap for the scroller; bit index = row*30 + col; 1 = ink.
REQ-011 o_cursor_x / o_cursor_y  output  5 each  current cursor cell, 0..29.
REQ-012 o_stroke_done  output  1  one-cycle pulse when a stroke completes.
REQ-013 o_busy  output  1  high while state is not IDLE.

Function
REQ-014 Cursor held as 10-bit unsigned positions px, py in the range 0..959; cell = position >> 5.
REQ-015 On i_valid: px += sign-extended dx, py -= sign-extended dy; results saturate to 0..959 with no wrap-around.
REQ-016 Paint: on i_valid with i_button_left=1, set the bit at the cell of the updated position; o_handwrite shows it on the next cycle (1-cycle latency).
REQ-017 Painting only sets bits and never clears them; repainting an inked cell is a no-op.
REQ-018 Clear: i_clear=1, or i_valid with i_button_right=1, zeroes all 900 bits on the next cycle; the cursor is unchanged.
REQ-019 Clear has priority over paint in the same cycle: the bitmap becomes all-zero, and the cursor still moves.
REQ-020 FSM states: IDLE, DRAW, HOLDOFF.
REQ-021 IDLE -> DRAW when i_valid=1 and left=1.
REQ-022 DRAW -> HOLDOFF when i_valid=1 and left=0; the counter is loaded with 0.
REQ-023 In HOLDOFF the counter increments every cycle; i_valid with left=0 moves the cursor but does not reset the counter.
REQ-024 HOLDOFF -> DRAW when i_valid=1 and left=1; the counter is cleared.
REQ-025 HOLDOFF -> IDLE when counter == TIMEOUT-1; o_stroke_done pulses for exactly one cycle on that transition.
REQ-026 Any clear (REQ-018) forces the FSM to IDLE from any state with no o_stroke_done pulse.
REQ-027 The counter width is ceil(log2(TIMEOUT)) and it never wraps; it is held at 0 outside HOLDOFF.

Reset
REQ-028 On i_rst_n low (asynchronous): o_handwrite=0, px=py=480 (cell 15,15), FSM=IDLE, counter=0, o_stroke_done=0, o_busy=0.
REQ-029 A reset mid-stroke discards all ink and all pending timeout; normal operation resumes on the first clock after i_rst_n rises.

Configuration
REQ-030 Macro HANDWRITE_THICK_EN defined: each paint event sets a 2x2 brush: cells (c,r), (c+1,r), (c,r+1) and (c+1,r+1), with any cell where c+1 or r+1 exceeds 29 omitted.
REQ-031 Macro HANDWRITE_THICK_EN undefined: each paint event sets the single cell (c,r) only; all other behaviour is identical.

Verification
REQ-032 Reset -> o_handwrite=0, cursor=(15,15), o_busy=0, o_stroke_done=0.
REQ-033 i_valid, left=1, dx=+32, dy=0 -> cursor=(16,15); next cycle bit 466 set, o_busy=1 (thick build: bits 466, 467, 496, 497 set).
REQ-034 Four packets with dx=+255, left=0 -> px=959 (saturated), cursor_x=29; then one packet dy=+255 -> py=225, cursor_y=7.
REQ-035 Press packet, release packet, then no packets (TIMEOUT=100) -> o_stroke_done high exactly once, 100 cycles after release, then o_busy=0.
REQ-036 i_clear=1 in the same cycle as a paint packet, during HOLDOFF -> bitmap all zero next cycle, FSM=IDLE, no o_stroke_done pulse.
REQ-037 Paint at cell (29,29) with HANDWRITE_THICK_EN defined -> only bit 899 set, no out-of-range write.
